npc_arch_state: RTL and testbench
=================================

// Module: npc_arch_state
// PURPOSE
//  Architectural-state block of the single-cycle NPC core: PC register, 2R/1W
//  integer register file and a key/value lookup decoder with default.
//  Sits between instruction decode (opcode -> control lookup) and
//  writeback/next-PC logic. Sequential state is written on the rising clk edge.
//  Reads and lookup are purely combinational.
// PARAMETERS
//  PC_RESET   32'h8000_0000  PC value loaded while reset is asserted
//  ADDR_W     5              register index width (2**ADDR_W registers)
//  XLEN       32             register and PC data width
//  NR_KEY     1              number of key/value pairs in the lookup table
//  KEY_LEN    7              lookup key width (opcode field)
//  DATA_LEN   1              lookup output width
// PORTS
//  clk          in   1                      clock, rising edge
//  rst          in   1                      reset; one clock; reset is synchronous and active-low
//  pc_wen       in   1                      PC update enable
//  pc_next      in   XLEN                   next PC value
//  pc           out  XLEN                   current PC (registered)
//  rf_wen       in   1                      register-file write enable
//  rf_waddr     in   ADDR_W                 write index
//  rf_wdata     in   XLEN                   write data
//  rs1addr      in   ADDR_W                 read port 1 index
//  rs2addr      in   ADDR_W                 read port 2 index
//  rs1data      out  XLEN                   read port 1 data
//  rs2data      out  XLEN                   read port 2 data
//  dec_key      in   KEY_LEN                lookup key
//  dec_default  in   DATA_LEN               output when no key matches
//  dec_lut      in   NR_KEY*(KEY_LEN+DATA_LEN)  packed {key,data} pairs
//  dec_out      out  DATA_LEN               lookup result
// BEHAVIOUR
//  - Reset (rst==0 at posedge clk): pc<=PC_RESET; all registers <=0. Reset wins
//    over pc_wen/rf_wen in the same cycle. Mid-operation reset takes effect at that edge.
//  - PC: at posedge, if rst==1 and pc_wen==1 then pc<=pc_next; otherwise hold.
//    No alignment check; any 32-bit value accepted. Wrap 0xFFFF_FFFC->0 is caller's.
//  - Reg file write: at posedge, if rst==1, rf_wen==1 and rf_waddr!=0,
//    reg[rf_waddr]<=rf_wdata. Writes to index 0 are discarded.
//  - Reg file read: combinational. rsNdata = (rsNaddr==0) ? 0 : reg[rsNaddr].
//    No write-to-read bypass: a read of the index being written in the same cycle
//    returns the old value until after the edge. Both ports may read the same index.
//  - Lookup: pair i occupies dec_lut[(i+1)*P-1 : i*P], P=KEY_LEN+DATA_LEN.
//    The key is the upper KEY_LEN bits and the data the lower DATA_LEN bits.
//    In a concatenation the first listed pair occupies the MSBs.
//    hit = OR over i of (dec_key==key_i). dec_out = hit ? OR of data_i over matching i : dec_default.
//    Keys are intended to be unique; duplicate keys give the bitwise OR of their data.
//    Pure combinational; X-free whenever inputs are known.
//  - No handshakes; zero-latency reads; one-cycle write latency for pc and registers.
// TESTING
//  1 rst=0 for 1 edge after writes to pc/x5 -> pc==0x8000_0000, rs1data(x5)==0
//  2 pc_wen=1, pc_next=0x8000_0004, one edge -> pc==0x8000_0004; pc_wen=0 -> holds
//  3 rf_wen=1 x5<=0xDEAD_BEEF; same cycle rs1addr=5 -> old 0; after edge rs1/rs2(5)==0xDEAD_BEEF
//  4 rf_wen=1 x0<=0x1234_5678 -> rs1data(0)==0; write x31=0xFFFF_FFFF, read both ports ok
//  5 NR_KEY=1, lut={7'b0000011,1'b1}, default 0: key 0000011 -> 1; key 0110011 -> 0
//  6 rst=0 asserted with pc_wen=1 and rf_wen=1 same edge -> pc==PC_RESET, no register write

Source files
------------

// File: rtl/npc_arch_state_if.sv
// rtl/npc_arch_state_if.sv - PC, register-file and decode-lookup signal bundle of the NPC core
interface npc_arch_state_if #(
  parameter int ADDR_W   = 5,
  parameter int XLEN     = 32,
  parameter int NR_KEY   = 1,
  parameter int KEY_LEN  = 7,
  parameter int DATA_LEN = 1
);
  logic                                  pc_wen;
  logic [XLEN-1:0]                       pc_next;
  logic [XLEN-1:0]                       pc;

  logic                                  rf_wen;
  logic [ADDR_W-1:0]                     rf_waddr;
  logic [XLEN-1:0]                       rf_wdata;
  logic [ADDR_W-1:0]                     rs1addr;
  logic [ADDR_W-1:0]                     rs2addr;
  logic [XLEN-1:0]                       rs1data;
  logic [XLEN-1:0]                       rs2data;

  logic [KEY_LEN-1:0]                    dec_key;
  logic [DATA_LEN-1:0]                   dec_default;
  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]  dec_lut;
  logic [DATA_LEN-1:0]                   dec_out;

  modport master (
    output pc_wen, pc_next, rf_wen, rf_waddr, rf_wdata, rs1addr, rs2addr,
           dec_key, dec_default, dec_lut,
    input  pc, rs1data, rs2data, dec_out
  );

  modport slave (
    input  pc_wen, pc_next, rf_wen, rf_waddr, rf_wdata, rs1addr, rs2addr,
           dec_key, dec_default, dec_lut,
    output pc, rs1data, rs2data, dec_out
  );
endinterface

// File: rtl/npc_arch_state.sv
// rtl/npc_arch_state.sv - NPC architectural state: PC register, 2R/1W register file, key/value decoder
// Sequential state updates on rising clk; reads and the lookup are combinational.
module npc_arch_state #(
  parameter logic [31:0] PC_RESET = 32'h8000_0000,
  parameter int          ADDR_W   = 5,
  parameter int          XLEN     = 32,
  parameter int          NR_KEY   = 1,
  parameter int          KEY_LEN  = 7,
  parameter int          DATA_LEN = 1
) (
  input  logic                clk,
  input  logic                rst,
  npc_arch_state_if.slave     bus
);
  localparam int NREG = 2 ** ADDR_W;
  localparam int P    = KEY_LEN + DATA_LEN;

  logic [XLEN-1:0] pc_q, pc_d;
  // x0 has no storage; reads of index 0 are forced to zero below.
  logic [XLEN-1:0] rf_q [1:NREG-1];

  always_comb begin
    pc_d = pc_q;
    if (bus.pc_wen) pc_d = bus.pc_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q <= XLEN'(PC_RESET);
    end else begin
      pc_q <= pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 1; i < NREG; i++) rf_q[i] <= '0;
    end else if (bus.rf_wen && (bus.rf_waddr != '0)) begin
      rf_q[bus.rf_waddr] <= bus.rf_wdata;
    end
  end

  assign bus.pc      = pc_q;
  assign bus.rs1data = (bus.rs1addr == '0) ? '0 : rf_q[bus.rs1addr];
  assign bus.rs2data = (bus.rs2addr == '0) ? '0 : rf_q[bus.rs2addr];

  // Matching entries are ORed so duplicate keys merge rather than prioritise.
  logic                hit;
  logic [DATA_LEN-1:0] hit_data;

  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      if (bus.dec_key == bus.dec_lut[i*P+DATA_LEN +: KEY_LEN]) begin
        hit      = 1'b1;
        hit_data = hit_data | bus.dec_lut[i*P +: DATA_LEN];
      end
    end
  end

  assign bus.dec_out = hit ? hit_data : bus.dec_default;
endmodule

// File: tb/tb_npc_arch_state.sv
// tb/tb_npc_arch_state.sv - directed self-checking bench for npc_arch_state
module tb_npc_arch_state;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  npc_arch_state_if #(.ADDR_W(5), .XLEN(32), .NR_KEY(1), .KEY_LEN(7), .DATA_LEN(1)) u_if ();
  npc_arch_state_if #(.ADDR_W(5), .XLEN(32), .NR_KEY(3), .KEY_LEN(7), .DATA_LEN(4)) u_if3 ();

  npc_arch_state #(.PC_RESET(32'h8000_0000), .ADDR_W(5), .XLEN(32),
                   .NR_KEY(1), .KEY_LEN(7), .DATA_LEN(1))
    u_dut (.clk(clk), .rst(rst), .bus(u_if.slave));

  // Wider lookup instance exercising pair ordering and duplicate-key merging.
  npc_arch_state #(.PC_RESET(32'h8000_0000), .ADDR_W(5), .XLEN(32),
                   .NR_KEY(3), .KEY_LEN(7), .DATA_LEN(4))
    u_dut3 (.clk(clk), .rst(rst), .bus(u_if3.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    u_if.pc_wen = 0; u_if.pc_next = '0;
    u_if.rf_wen = 0; u_if.rf_waddr = '0; u_if.rf_wdata = '0;
    u_if.rs1addr = '0; u_if.rs2addr = '0;
    u_if.dec_key = '0; u_if.dec_default = '0; u_if.dec_lut = '0;
    u_if3.pc_wen = 0; u_if3.pc_next = '0;
    u_if3.rf_wen = 0; u_if3.rf_waddr = '0; u_if3.rf_wdata = '0;
    u_if3.rs1addr = '0; u_if3.rs2addr = '0;
    u_if3.dec_key = '0; u_if3.dec_default = '0; u_if3.dec_lut = '0;

    tick();
    check("reset_pc", u_if.pc, 32'h8000_0000);

    // Dirty pc and x5, then reset.
    rst = 1'b1;
    u_if.pc_wen = 1; u_if.pc_next = 32'h0000_1234;
    u_if.rf_wen = 1; u_if.rf_waddr = 5'd5; u_if.rf_wdata = 32'hAAAA_5555;
    u_if.rs1addr = 5'd5;
    tick();
    u_if.pc_wen = 0; u_if.rf_wen = 0;
    check("pre_reset_pc", u_if.pc, 32'h0000_1234);
    check("pre_reset_x5", u_if.rs1data, 32'hAAAA_5555);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("t1_pc", u_if.pc, 32'h8000_0000);
    check("t1_x5", u_if.rs1data, 32'h0);

    u_if.pc_wen = 1; u_if.pc_next = 32'h8000_0004;
    tick();
    check("t2_pc_update", u_if.pc, 32'h8000_0004);
    u_if.pc_wen = 0; u_if.pc_next = 32'hFFFF_FFFC;
    tick();
    check("t2_pc_hold", u_if.pc, 32'h8000_0004);
    u_if.pc_wen = 1;
    tick();
    check("pc_any_value", u_if.pc, 32'hFFFF_FFFC);
    u_if.pc_wen = 0;

    u_if.rf_wen = 1; u_if.rf_waddr = 5'd5; u_if.rf_wdata = 32'hDEAD_BEEF;
    u_if.rs1addr = 5'd5; u_if.rs2addr = 5'd5;
    #1;
    check("t3_no_bypass", u_if.rs1data, 32'h0);
    tick();
    u_if.rf_wen = 0;
    check("t3_rs1_x5", u_if.rs1data, 32'hDEAD_BEEF);
    check("t3_rs2_x5", u_if.rs2data, 32'hDEAD_BEEF);

    u_if.rf_wen = 1; u_if.rf_waddr = 5'd0; u_if.rf_wdata = 32'h1234_5678;
    tick();
    u_if.rs1addr = 5'd0; u_if.rs2addr = 5'd0;
    #1;
    check("t4_x0_rs1", u_if.rs1data, 32'h0);
    check("t4_x0_rs2", u_if.rs2data, 32'h0);
    u_if.rf_waddr = 5'd31; u_if.rf_wdata = 32'hFFFF_FFFF;
    tick();
    u_if.rf_wen = 0; u_if.rf_wdata = 32'h0BAD_0BAD;
    u_if.rs1addr = 5'd31; u_if.rs2addr = 5'd5;
    #1;
    check("t4_x31_rs1", u_if.rs1data, 32'hFFFF_FFFF);
    check("t4_x5_rs2", u_if.rs2data, 32'hDEAD_BEEF);
    tick();
    check("wen_low_hold", u_if.rs1data, 32'hFFFF_FFFF);

    // Reset wins over simultaneous pc and register writes.
    rst = 1'b0;
    u_if.pc_wen = 1; u_if.pc_next = 32'h0000_0044;
    u_if.rf_wen = 1; u_if.rf_waddr = 5'd7; u_if.rf_wdata = 32'h0000_0077;
    tick();
    rst = 1'b1; u_if.pc_wen = 0; u_if.rf_wen = 0;
    u_if.rs1addr = 5'd7; u_if.rs2addr = 5'd31;
    #1;
    check("t6_pc", u_if.pc, 32'h8000_0000);
    check("t6_x7", u_if.rs1data, 32'h0);
    check("t6_x31", u_if.rs2data, 32'h0);

    u_if.dec_lut = {7'b0000011, 1'b1}; u_if.dec_default = 1'b0;
    u_if.dec_key = 7'b0000011;
    #1;
    check("t5_hit", 32'(u_if.dec_out), 32'h1);
    u_if.dec_key = 7'b0110011;
    #1;
    check("t5_miss", 32'(u_if.dec_out), 32'h0);
    u_if.dec_default = 1'b1;
    #1;
    check("t5_miss_def1", 32'(u_if.dec_out), 32'h1);
    u_if.dec_lut = {7'b0110011, 1'b0};
    #1;
    check("t5_hit_data0", 32'(u_if.dec_out), 32'h0);

    u_if3.dec_lut = {7'h03, 4'h1, 7'h13, 4'h2, 7'h03, 4'h8};
    u_if3.dec_default = 4'h5;
    u_if3.dec_key = 7'h13;
    #1;
    check("lut3_mid", 32'(u_if3.dec_out), 32'h2);
    u_if3.dec_key = 7'h03;
    #1;
    check("lut3_dup_or", 32'(u_if3.dec_out), 32'h9);
    u_if3.dec_key = 7'h33;
    #1;
    check("lut3_default", 32'(u_if3.dec_out), 32'h5);
    u_if3.dec_lut = {7'h6F, 4'hC, 7'h13, 4'h2, 7'h37, 4'h8};
    u_if3.dec_key = 7'h6F;
    #1;
    check("lut3_msb_pair", 32'(u_if3.dec_out), 32'hC);
    u_if3.dec_key = 7'h37;
    #1;
    check("lut3_lsb_pair", 32'(u_if3.dec_out), 32'h8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
